// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight destination registers
// from ID/EX onward and drives EX forward selects, the ID stall and a stall counter.
module fwd_hazard_unit #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_W-1:0]           id_rd,
    input  logic                       id_reg_write,
    input  logic                       id_mem_read,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic                       flush,
    output logic                       stall,
    output logic [NUM_SRC*SEL_W-1:0]   forward_sel,
    output logic [15:0]                stall_count
);

    // Shadow stage k: 0 = ID/EX, k >= 1 = k stages past EX.
    logic               r_valid [0:FWD_DEPTH];
    logic [REG_W-1:0]   r_rd    [0:FWD_DEPTH];
    logic               r_rw    [0:FWD_DEPTH];
    logic               r_mr    [0:FWD_DEPTH];
    logic [NUM_SRC*REG_W-1:0] r_ex_src;
    logic [15:0]        r_stall_count;

    logic [NUM_SRC*SEL_W-1:0] w_forward_sel;
    logic               w_load_hit;
    logic               w_insert;

    always_comb begin
        w_forward_sel = '0;
        w_load_hit    = 1'b0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            // Ascending scan; the first hit (youngest producer) is kept.
            for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
                if (r_valid[k] && r_rw[k] && (r_rd[k] != '0) &&
                    (r_rd[k] == r_ex_src[s*REG_W +: REG_W]) &&
                    (w_forward_sel[s*SEL_W +: SEL_W] == '0)) begin
                    w_forward_sel[s*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
            for (int unsigned j = 0; j < LOAD_LAT; j++) begin
                if (r_valid[j] && r_rw[j] && r_mr[j] && (r_rd[j] != '0) &&
                    (r_rd[j] == id_src[s*REG_W +: REG_W])) begin
                    w_load_hit = 1'b1;
                end
            end
        end
    end

    assign stall       = id_valid & ~flush & w_load_hit;
    assign w_insert    = id_valid & ~flush & ~w_load_hit;
    assign forward_sel = w_forward_sel;
    assign stall_count = r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= FWD_DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_rd[k]    <= '0;
                r_rw[k]    <= 1'b0;
                r_mr[k]    <= 1'b0;
            end
            r_ex_src      <= '0;
            r_stall_count <= '0;
        end else begin
            for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_rw[k]    <= r_rw[k-1];
                r_mr[k]    <= r_mr[k-1];
            end
            if (w_insert) begin
                r_valid[0] <= 1'b1;
                r_rd[0]    <= id_rd;
                r_rw[0]    <= id_reg_write;
                r_mr[0]    <= id_mem_read;
                r_ex_src   <= id_src;
            end else begin
                r_valid[0] <= 1'b0;
                r_rd[0]    <= '0;
                r_rw[0]    <= 1'b0;
                r_mr[0]    <= 1'b0;
                r_ex_src   <= '0;
            end
            if (stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: default, widened and deep-load instances.
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic [1:0]  dut;
        logic        only_cnt;
        logic        stall;
        logic [31:0] sel;
        logic [15:0] cnt;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic  clk      = 1'b0;
    logic  c_done   = 1'b0;

    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_rst, a_valid, a_rw, a_mr, a_flush, a_stall;
    logic [4:0]  a_rd;
    logic [9:0]  a_src;
    logic [3:0]  a_sel;
    logic [15:0] a_cnt;

    fwd_hazard_unit u_a (
        .clk(clk), .rst(a_rst), .id_valid(a_valid), .id_rd(a_rd),
        .id_reg_write(a_rw), .id_mem_read(a_mr), .id_src(a_src), .flush(a_flush),
        .stall(a_stall), .forward_sel(a_sel), .stall_count(a_cnt)
    );

    // Instance B: three operands, deeper forwarding, two-cycle load
    logic        b_rst, b_valid, b_rw, b_mr, b_flush, b_stall;
    logic [4:0]  b_rd;
    logic [14:0] b_src;
    logic [5:0]  b_sel;
    logic [15:0] b_cnt;

    fwd_hazard_unit #(.REG_W(5), .NUM_SRC(3), .FWD_DEPTH(3), .LOAD_LAT(2)) u_b (
        .clk(clk), .rst(b_rst), .id_valid(b_valid), .id_rd(b_rd),
        .id_reg_write(b_rw), .id_mem_read(b_mr), .id_src(b_src), .flush(b_flush),
        .stall(b_stall), .forward_sel(b_sel), .stall_count(b_cnt)
    );

    // Instance C: long load latency, used to drive the counter into saturation
    logic        c_rst, c_valid, c_rw, c_mr, c_flush, c_stall;
    logic [4:0]  c_rd;
    logic [4:0]  c_src;
    logic [4:0]  c_sel;
    logic [15:0] c_cnt;

    fwd_hazard_unit #(.REG_W(5), .NUM_SRC(1), .FWD_DEPTH(16), .LOAD_LAT(15)) u_c (
        .clk(clk), .rst(c_rst), .id_valid(c_valid), .id_rd(c_rd),
        .id_reg_write(c_rw), .id_mem_read(c_mr), .id_src(c_src), .flush(c_flush),
        .stall(c_stall), .forward_sel(c_sel), .stall_count(c_cnt)
    );

    task automatic push_exp(input logic [1:0] d, input string nm, input logic oc,
                            input logic st, input logic [31:0] sl, input logic [15:0] ct);
        exp_t e;
        e.dut = d; e.only_cnt = oc; e.stall = st; e.sel = sl; e.cnt = ct;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic step_a(input logic r, input logic v, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic [4:0] s0,
                          input logic [4:0] s1, input logic fl, input string nm,
                          input logic st, input logic [3:0] sl, input logic [15:0] ct);
        @(posedge clk);
        #1;
        a_rst = r; a_valid = v; a_rd = rd; a_rw = rw; a_mr = mr;
        a_src = {s1, s0}; a_flush = fl;
        push_exp(2'd0, nm, 1'b0, st, 32'(sl), ct);
    endtask

    task automatic step_b(input logic v, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [4:0] s2, input string nm, input logic st,
                          input logic [5:0] sl, input logic [15:0] ct);
        @(posedge clk);
        #1;
        b_valid = v; b_rd = rd; b_rw = rw; b_mr = mr; b_src = {s2, s1, s0}; b_flush = 1'b0;
        push_exp(2'd1, nm, 1'b0, st, 32'(sl), ct);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        string       nm;
        logic        st;
        logic [31:0] sl;
        logic [15:0] ct;
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            case (e.dut)
                2'd0:    begin st = a_stall; sl = 32'(a_sel); ct = a_cnt; end
                2'd1:    begin st = b_stall; sl = 32'(b_sel); ct = b_cnt; end
                default: begin st = c_stall; sl = 32'(c_sel); ct = c_cnt; end
            endcase
            if (!e.only_cnt) begin
                checks++;
                if (st !== e.stall) begin
                    failures++;
                    $display("FAIL %s stall actual=%0b required=%0b", nm, st, e.stall);
                end
                checks++;
                if (sl !== e.sel) begin
                    failures++;
                    $display("FAIL %s forward_sel actual=%0h required=%0h", nm, sl, e.sel);
                end
            end
            checks++;
            if (ct !== e.cnt) begin
                failures++;
                $display("FAIL %s stall_count actual=%0d required=%0d", nm, ct, e.cnt);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Instance C: a load re-reading its own rd stalls 15 of every 16 cycles.
    initial begin
        c_rst = 1'b1; c_valid = 1'b0; c_rd = '0; c_rw = 1'b0; c_mr = 1'b0;
        c_src = '0; c_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        c_rst = 1'b0;
        push_exp(2'd2, "C_reset", 1'b0, 1'b0, 32'd0, 16'd0);
        @(posedge clk);
        #1;
        c_valid = 1'b1; c_rd = 5'd2; c_rw = 1'b1; c_mr = 1'b1; c_src = 5'd2;
        push_exp(2'd2, "C_first_load", 1'b0, 1'b0, 32'd0, 16'd0);
        @(posedge clk);
        #1;
        push_exp(2'd2, "C_stall_begin", 1'b0, 1'b1, 32'd0, 16'd0);
        repeat (15) @(posedge clk);
        #1;
        push_exp(2'd2, "C_release", 1'b0, 1'b0, 32'd0, 16'd15);
        @(posedge clk);
        #1;
        push_exp(2'd2, "C_fwd16", 1'b0, 1'b1, 32'd16, 16'd15);
        repeat (70000) @(posedge clk);
        #1;
        push_exp(2'd2, "C_saturate", 1'b1, 1'b0, 32'd0, 16'hFFFF);
        c_done = 1'b1;
    end

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_rd = '0; a_rw = 1'b0; a_mr = 1'b0;
        a_src = '0; a_flush = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_rd = '0; b_rw = 1'b0; b_mr = 1'b0;
        b_src = '0; b_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        push_exp(2'd0, "A_reset", 1'b0, 1'b0, 32'd0, 16'd0);
        push_exp(2'd1, "B_reset", 1'b0, 1'b0, 32'd0, 16'd0);

        //     r  v  rd  rw mr s0  s1  fl  name               st sel      cnt
        step_a(0, 1, 3,  1, 0, 1,  2,  0, "b2b_prod",         0, 4'b0000, 0);
        step_a(0, 1, 5,  1, 0, 3,  3,  0, "b2b_cons_id",      0, 4'b0000, 0);
        step_a(0, 0, 0,  0, 0, 0,  0,  0, "b2b_ex",           0, 4'b0101, 0);
        step_a(0, 1, 3,  1, 0, 0,  0,  0, "two_prod",         0, 4'b0000, 0);
        step_a(0, 0, 0,  0, 0, 0,  0,  0, "two_gap",          0, 4'b0000, 0);
        step_a(0, 1, 6,  1, 0, 3,  4,  0, "two_cons_id",      0, 4'b0000, 0);
        step_a(0, 0, 0,  0, 0, 0,  0,  0, "two_ex",           0, 4'b0010, 0);
        step_a(0, 1, 3,  1, 0, 0,  0,  0, "young_p1",         0, 4'b0000, 0);
        step_a(0, 1, 3,  1, 0, 0,  0,  0, "young_p2",         0, 4'b0000, 0);
        step_a(0, 1, 8,  1, 0, 3,  9,  0, "young_cons_id",    0, 4'b0000, 0);
        step_a(0, 0, 0,  0, 0, 0,  0,  0, "young_ex",         0, 4'b0001, 0);
        step_a(0, 1, 2,  1, 1, 1,  0,  0, "lu_load",          0, 4'b0000, 0);
        step_a(0, 1, 7,  1, 0, 2,  1,  0, "lu_stall",         1, 4'b0000, 0);
        step_a(0, 1, 7,  1, 0, 2,  1,  0, "lu_release",       0, 4'b0000, 1);
        step_a(0, 0, 0,  0, 0, 0,  0,  0, "lu_ex",            0, 4'b0010, 1);
        step_a(0, 1, 0,  1, 0, 0,  0,  0, "r0_prod",          0, 4'b0000, 1);
        step_a(0, 1, 4,  0, 0, 0,  0,  0, "nowr_prod",        0, 4'b0000, 1);
        step_a(0, 1, 8,  1, 0, 0,  4,  0, "r0_cons_id",       0, 4'b0000, 1);
        step_a(0, 0, 0,  0, 0, 0,  0,  0, "r0_nowr_ex",       0, 4'b0000, 1);
        step_a(0, 1, 0,  1, 1, 0,  0,  0, "lw_r0",            0, 4'b0000, 1);
        step_a(0, 1, 8,  1, 0, 0,  0,  0, "lw_r0_cons",       0, 4'b0000, 1);
        step_a(0, 1, 9,  1, 1, 0,  0,  0, "fl_load",          0, 4'b0000, 1);
        step_a(0, 1, 10, 1, 0, 9,  9,  1, "fl_hazard",        0, 4'b0000, 1);
        step_a(0, 0, 0,  0, 0, 0,  0,  0, "fl_bubble",        0, 4'b0000, 1);
        step_a(0, 1, 11, 1, 1, 0,  0,  0, "rs_load",          0, 4'b0000, 1);
        step_a(1, 1, 12, 1, 0, 11, 0,  0, "rs_stall",         1, 4'b0000, 1);
        step_a(0, 1, 12, 1, 0, 11, 0,  0, "rs_after",         0, 4'b0000, 0);
        step_a(0, 0, 0,  0, 0, 0,  0,  0, "rs_cleared",       0, 4'b0000, 0);

        //     v  rd  rw mr s0 s1 s2  name         st sel        cnt
        step_b(1, 2,  1, 1, 0, 0, 0, "B_load",     0, 6'b000000, 0);
        step_b(1, 7,  1, 0, 1, 5, 2, "B_stall1",   1, 6'b000000, 0);
        step_b(1, 7,  1, 0, 1, 5, 2, "B_stall2",   1, 6'b000000, 1);
        step_b(1, 7,  1, 0, 1, 5, 2, "B_release",  0, 6'b000000, 2);
        step_b(0, 0,  0, 0, 0, 0, 0, "B_ex3",      0, 6'b110000, 2);
        step_b(1, 4,  1, 0, 0, 0, 0, "B_p4",       0, 6'b000000, 2);
        step_b(1, 5,  1, 0, 0, 0, 0, "B_p5",       0, 6'b000000, 2);
        step_b(1, 6,  1, 0, 0, 0, 0, "B_p6",       0, 6'b000000, 2);
        step_b(1, 13, 1, 0, 6, 5, 4, "B_cons",     0, 6'b000000, 2);
        step_b(0, 0,  0, 0, 0, 0, 0, "B_ex_all",   0, 6'b111001, 2);

        wait (c_done);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
